// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between countdown_ctrl, its host and scaledclock.
// Master drives commands and the tick source, slave is the controller.
interface countdown_ctrl_if #(
  parameter int WIDTH = 7
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             scaledclk;
  logic             enable;
  logic [WIDTH-1:0] remaining;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             running;
  logic             done;
  logic             alarm;

  modport master (
    output load, load_val, start, stop, scaledclk,
    input  enable, remaining, tens, ones, running, done, alarm
  );

  modport slave (
    input  load, load_val, start, stop, scaledclk,
    output enable, remaining, tens, ones, running, done, alarm
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Seconds countdown driven by scaledclock ticks, with alarm and
// registered BCD digits of the remaining count.
module countdown_ctrl #(
  parameter int MAX_COUNT = 99,
  parameter int WIDTH     = 7
) (
  input  logic            clock,
  input  logic            reset_n,
  countdown_ctrl_if.slave cif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] TEN   = WIDTH'(10);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             sclk_q;
  logic             enable_q, enable_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             alarm_q, alarm_d;
  logic             tick;
  logic [WIDTH-1:0] sat_val;

  always_comb begin
    tick    = cif.scaledclk & ~sclk_q;
    sat_val = (cif.load_val > MAX_V) ? MAX_V : cif.load_val;
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    case (state_q)
      S_RUN: begin
        // A tick and stop in one cycle: decrement first, zero beats pause.
        if (tick) begin
          rem_d = rem_q - ONE;
        end
        if (tick && (rem_q == ONE)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cif.stop) begin
          state_d = S_PAUSE;
        end
      end
      S_IDLE, S_PAUSE, S_DONE: begin
        if (cif.load) begin
          rem_d   = sat_val;
          state_d = S_IDLE;
        end else if (cif.stop) begin
          if (state_q == S_DONE) begin
            state_d = S_IDLE;
          end
        end else if (cif.start) begin
          if (state_q == S_DONE) begin
            state_d = S_IDLE;
          end else if ((state_q == S_PAUSE) ||
                       (rem_q != '0)) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tens_d    = 4'(rem_q / TEN);
    ones_d    = 4'(rem_q % TEN);
    enable_d  = (state_d == S_RUN);
    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      sclk_q    <= 1'b0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      sclk_q    <= cif.scaledclk;
      enable_q  <= enable_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign cif.enable    = enable_q;
  assign cif.remaining = rem_q;
  assign cif.tens      = tens_q;
  assign cif.ones      = ones_q;
  assign cif.running   = running_q;
  assign cif.done      = done_q;
  assign cif.alarm     = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed plan plus random traffic for countdown_ctrl, checked
// against a behavioural model of the timer.
module tb_countdown_ctrl;

  localparam int WIDTH = 7;
  localparam int MAXC  = 99;

  typedef enum int {M_IDLE, M_RUN, M_HOLD, M_ALARM} mode_e;

  logic clock = 1'b0;
  logic reset_n;

  countdown_ctrl_if #(.WIDTH(WIDTH)) cif ();

  countdown_ctrl #(
    .MAX_COUNT(MAXC),
    .WIDTH    (WIDTH)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .cif    (cif)
  );

  always #5 clock = ~clock;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    done_seen;
  mode_e m_mode;
  int    m_rem, m_tens, m_ones;
  bit    m_done, m_sclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: one clock edge worth of timer behaviour.
  task automatic model_step(input bit ld, input int lv,
                            input bit st, input bit sp,
                            input bit sc, input bit rn);
    int prev;
    bit tick;
    prev = m_rem;
    tick = sc && !m_sclk;
    if (!rn) begin
      m_mode = M_IDLE;
      m_rem  = 0;
      m_tens = 0;
      m_ones = 0;
      m_done = 0;
      m_sclk = 0;
      return;
    end
    m_sclk = sc;
    m_done = 0;
    m_tens = prev / 10;
    m_ones = prev % 10;
    if (m_mode == M_RUN) begin
      if (tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode = M_ALARM;
          m_done = 1;
        end
      end
      if (sp && m_mode == M_RUN) m_mode = M_HOLD;
    end else if (ld) begin
      m_rem  = (lv > MAXC) ? MAXC : lv;
      m_mode = M_IDLE;
    end else if (sp) begin
      if (m_mode == M_ALARM) m_mode = M_IDLE;
    end else if (st) begin
      if (m_mode == M_ALARM) m_mode = M_IDLE;
      else if (m_mode == M_HOLD) m_mode = M_RUN;
      else if (m_rem > 0) m_mode = M_RUN;
    end
  endtask

  task automatic check_all();
    chk("remaining", int'(cif.remaining), m_rem);
    chk("tens", int'(cif.tens), m_tens);
    chk("ones", int'(cif.ones), m_ones);
    chk("enable", int'(cif.enable), int'(m_mode == M_RUN));
    chk("running", int'(cif.running), int'(m_mode == M_RUN));
    chk("done", int'(cif.done), int'(m_done));
    chk("alarm", int'(cif.alarm), int'(m_mode == M_ALARM));
  endtask

  // Called at a falling edge: drive, advance model, check next fall.
  task automatic cyc(input bit ld = 0, input int lv = 0,
                     input bit st = 0, input bit sp = 0,
                     input bit sc = 0, input bit rn = 1);
    cif.load      = ld;
    cif.load_val  = WIDTH'(lv);
    cif.start     = st;
    cif.stop      = sp;
    cif.scaledclk = sc;
    reset_n       = rn;
    model_step(ld, lv, st, sp, sc, rn);
    @(negedge clock);
    check_all();
    if (cif.done) done_seen++;
  endtask

  task automatic tick_once();
    cyc(.sc(1));
    cyc(.sc(0));
  endtask

  initial begin
    int  sc_left;
    bit  sc_lvl;
    int  r, lv;
    bit  ld, st, sp, rn;
    cif.load      = 0;
    cif.load_val  = '0;
    cif.start     = 0;
    cif.stop      = 0;
    cif.scaledclk = 0;
    reset_n       = 0;
    m_mode = M_IDLE;
    m_rem = 0; m_tens = 0; m_ones = 0;
    m_done = 0; m_sclk = 0;
    done_seen = 0;
    @(negedge clock);

    repeat (3) cyc(.rn(0));
    chk("rst_rem", int'(cif.remaining), 0);
    chk("rst_enable", int'(cif.enable), 0);
    cyc(.ld(1), .lv(42));
    chk("load42", int'(cif.remaining), 42);
    cyc();
    chk("tens42", int'(cif.tens), 4);
    chk("ones42", int'(cif.ones), 2);
    chk("enable42", int'(cif.enable), 0);

    cyc(.ld(1), .lv(3));
    cyc(.st(1));
    chk("start_en", int'(cif.enable), 1);
    done_seen = 0;
    tick_once();
    chk("cd_2", int'(cif.remaining), 2);
    tick_once();
    chk("cd_1", int'(cif.remaining), 1);
    cyc(.sc(1));
    chk("cd_done", int'(cif.done), 1);
    chk("cd_0", int'(cif.remaining), 0);
    cyc();
    chk("cd_alarm", int'(cif.alarm), 1);
    chk("cd_en0", int'(cif.enable), 0);
    chk("cd_done_cnt", done_seen, 1);
    cyc(.sp(1));
    chk("ack_alarm", int'(cif.alarm), 0);

    cyc(.ld(1), .lv(10));
    cyc(.st(1));
    repeat (4) tick_once();
    chk("pause_6", int'(cif.remaining), 6);
    cyc(.sp(1));
    chk("pause_en", int'(cif.enable), 0);
    repeat (2) tick_once();
    chk("frozen_6", int'(cif.remaining), 6);
    cyc(.st(1));
    tick_once();
    chk("resume_5", int'(cif.remaining), 5);
    cyc(.sp(1));

    cyc(.ld(1), .lv(120));
    chk("sat_99", int'(cif.remaining), 99);
    cyc();
    chk("sat_tens", int'(cif.tens), 9);
    chk("sat_ones", int'(cif.ones), 9);
    cyc(.ld(1), .lv(0));
    cyc(.st(1));
    chk("zero_run", int'(cif.running), 0);
    chk("zero_en", int'(cif.enable), 0);

    cyc(.ld(1), .lv(2));
    cyc(.st(1));
    tick_once();
    chk("sim_1", int'(cif.remaining), 1);
    cyc(.sp(1), .sc(1));
    chk("sim_done", int'(cif.done), 1);
    chk("sim_alarm", int'(cif.alarm), 1);
    cyc();
    cyc(.st(1));

    cyc(.ld(1), .lv(10));
    cyc(.st(1));
    tick_once();
    cyc(.sp(1));
    cyc(.ld(1), .lv(7), .st(1));
    chk("ldst_run", int'(cif.running), 0);
    chk("ldst_rem", int'(cif.remaining), 7);

    cyc(.ld(1), .lv(50));
    cyc(.st(1));
    repeat (5) tick_once();
    chk("mid_45", int'(cif.remaining), 45);
    cyc(.sc(1), .rn(0));
    chk("mid_rem", int'(cif.remaining), 0);
    chk("mid_done", int'(cif.done), 0);
    chk("mid_en", int'(cif.enable), 0);

    sc_left = 1;
    sc_lvl  = 0;
    repeat (3000) begin
      sc_left--;
      if (sc_left == 0) begin
        sc_lvl  = !sc_lvl;
        sc_left = $urandom_range(1, 4);
      end
      r  = $urandom_range(0, 99);
      ld = (r < 4) && (m_mode != M_RUN);
      st = (r >= 4) && (r < 12);
      sp = (r >= 12) && (r < 17);
      rn = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 1) == 1) lv = $urandom_range(1, 6);
      else lv = $urandom_range(0, 127);
      cyc(ld, lv, st, sp, sc_lvl, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
